alu_pipe: RTL and testbench
===========================

ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 SHALL have parameter: WIDTH, 16, operand/result width in bits (legal range 4..32).
REQ-002 SHALL have port: clk  input  1  rising-edge clock.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: in_valid  input  1  operation presented.
REQ-005 SHALL have port: in_ready  output  1  operation accepted when in_valid && in_ready.
REQ-006 SHALL have port: R  input  WIDTH  operand R.
REQ-007 SHALL have port: S  input  WIDTH  operand S.
REQ-008 SHALL have port: Alu_Op  input  4  opcode.
REQ-009 SHALL have port: out_valid  output  1  result registers hold a valid result.
REQ-010 SHALL have port: out_ready  input  1  consumer takes the result when out_valid && out_ready.
REQ-011 SHALL have port: Y  output  WIDTH  registered result.
REQ-012 SHALL have ports: N, Z, C, V  output  1 each  registered negative, zero, carry/borrow and signed-overflow flags.
REQ-013 SHALL have port: err  output  1  registered illegal-opcode flag.
REQ-014 SHALL have port: busy  output  1  multiply in progress.

Function
REQ-015 SHALL decode opcodes as follows:
- 0 pass S
- 1 pass R
- 2 S+1
- 3 S-1
- 4 R+S
- 5 R-S
- 6 logical shift right S
- 7 shift left S
- 8 AND
- 9 OR
- 10 XOR
- 11 ~S
- 12 -S
- 13 MUL (low WIDTH bits of R*S, unsigned)
- 14-15 illegal
REQ-016 SHALL capture opcodes 0-12 and 14-15 on acceptance and present the result, with out_valid=1, on the next rising edge (latency 1).
REQ-017 SHALL drive in_ready = !busy && (!out_valid || out_ready), so that single-cycle operations sustain one per clock under continuous out_ready.
REQ-018 SHALL hold Y, N, Z, C, V, err and out_valid stable while out_valid && !out_ready.
REQ-019 SHALL clear out_valid after an out_valid && out_ready handshake if no new result loads on that edge.
REQ-020 SHALL set N = Y[WIDTH-1] and Z = (Y == 0) for every result.
REQ-021 SHALL set C as follows, and 0 for all other opcodes:
- add: carry-out
- sub: borrow (R < S unsigned)
- inc: S all-ones
- dec: S == 0
- shr: S[0]
- shl: S[WIDTH-1]
- neg: S != 0
- MUL: any nonzero high product bit
REQ-022 SHALL set V to signed overflow for add and sub, and 0 for all other opcodes.
REQ-023 SHALL, for illegal opcodes, produce Y = 0, err = 1, C = V = 0, with Z = 1 per REQ-020; err SHALL be 0 for all legal opcodes.
REQ-024 SHALL implement MUL with a two-state FSM:
- IDLE -> MULT on acceptance of opcode 13
- MULT runs WIDTH shift-add iterations, one per clock
- MULT -> IDLE on the final iteration, loading the result registers with out_valid=1
REQ-025 SHALL make MUL latency WIDTH+1 clocks from the accepting edge to out_valid.
REQ-026 SHALL assert busy and deassert in_ready throughout MULT.
REQ-027 SHALL allow an earlier result to be consumed during MULT; if that result is still unconsumed at the final iteration, MULT SHALL stall (busy held) until out_ready.
REQ-028 SHALL compute all arithmetic modulo 2^WIDTH, with carries taken from a WIDTH+1-bit sum.

Reset
REQ-029 SHALL, on reset low, immediately clear:
- FSM to IDLE
- Y to 0
- N, Z, C, V, err, out_valid and busy to 0
- the multiply accumulator and iteration counter
REQ-030 SHALL abort an in-progress MUL on reset and produce no result for it.
REQ-031 SHALL hold in_ready low while reset is asserted and assert it on the first clock after release.

Configuration
REQ-032 SHALL compile the multiplier FSM and datapath only when macro ALU_PIPE_MUL_EN is defined.
REQ-033 SHALL, without ALU_PIPE_MUL_EN:
- treat opcode 13 as illegal per REQ-023
- tie busy to 0
- implement no MULT state

Verification
REQ-034 SHALL verify: WIDTH=16, op 4, R=BC45, S=86AB, out_ready=1 -> next cycle Y=42F0, C=1, V=1, N=0, Z=0.
REQ-035 SHALL verify: op 5 R=BD53 S=5555 then op 12 S=DF52 on consecutive cycles -> Y=67FE (C=0, V=1), then Y=20AE (C=1), on consecutive cycles.
REQ-036 SHALL verify: out_ready=0 with op 1 R=9ABC -> Y=9ABC, N=1 held and in_ready=0 for 5 cycles; out_ready=1 -> handshake, then out_valid=0.
REQ-037 SHALL verify, with MUL_EN: op 13 R=0100 S=0100 -> busy for 16 cycles, out_valid on cycle 17, Y=0000, Z=1, C=1.
REQ-038 SHALL verify: reset low 3 cycles into a MUL -> all outputs 0 at once, no out_valid after release, the next op 2 S=FFFF gives Y=0000, Z=1, C=1.
REQ-039 SHALL verify: op 14 -> err=1, Y=0; and op 13 without MUL_EN -> err=1, busy never set.

Source files
------------

// File: rtl/alu_pipe.sv
// alu_pipe: valid/ready ALU with registered result and N/Z/C/V/err flags, latency 1.
// Define ALU_PIPE_MUL_EN to build the multi-cycle shift-add multiplier (opcode 13).
module alu_pipe #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] R,
    input  logic [WIDTH-1:0] S,
    input  logic [3:0]       Alu_Op,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Y,
    output logic             N,
    output logic             Z,
    output logic             C,
    output logic             V,
    output logic             err,
    output logic             busy
);

    logic [WIDTH-1:0] y_q, y_d;
    logic             n_q, n_d, z_q, z_d, c_q, c_d, v_q, v_d;
    logic             err_q, err_d, vld_q, vld_d;
    logic             rdy_en_q;
    logic             accept, is_mul;

    logic [WIDTH:0]   sum, diff;
    logic [WIDTH-1:0] res;
    logic             res_c, res_v, res_err;

`ifdef ALU_PIPE_MUL_EN
    localparam int CW = $clog2(WIDTH);

    typedef enum logic {IDLE, MULT} state_t;
    state_t             state_q, state_d;
    logic [2*WIDTH-1:0] acc_q, acc_d, mcand_q, mcand_d, prod;
    logic [WIDTH-1:0]   mplier_q, mplier_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    assign busy   = (state_q == MULT);
    assign is_mul = (Alu_Op == 4'd13);
`else
    assign busy   = 1'b0;
    assign is_mul = 1'b0;
`endif

    // in_ready stays low until the first clock edge after reset release
    assign in_ready  = rdy_en_q && !busy && (!vld_q || out_ready);
    assign accept    = in_valid && in_ready;

    assign out_valid = vld_q;
    assign Y         = y_q;
    assign N         = n_q;
    assign Z         = z_q;
    assign C         = c_q;
    assign V         = v_q;
    assign err       = err_q;

    always_comb begin
        sum     = {1'b0, R} + {1'b0, S};
        diff    = {1'b0, R} - {1'b0, S};
        res     = '0;
        res_c   = 1'b0;
        res_v   = 1'b0;
        res_err = 1'b0;
        case (Alu_Op)
            4'd0:  res = S;
            4'd1:  res = R;
            4'd2:  begin res = S + WIDTH'(1); res_c = &S;  end
            4'd3:  begin res = S - WIDTH'(1); res_c = ~|S; end
            4'd4: begin
                res   = sum[WIDTH-1:0];
                res_c = sum[WIDTH];
                res_v = (R[WIDTH-1] == S[WIDTH-1]) && (sum[WIDTH-1] != R[WIDTH-1]);
            end
            4'd5: begin
                res   = diff[WIDTH-1:0];
                res_c = diff[WIDTH];
                res_v = (R[WIDTH-1] != S[WIDTH-1]) && (diff[WIDTH-1] != R[WIDTH-1]);
            end
            4'd6:  begin res = {1'b0, S[WIDTH-1:1]}; res_c = S[0];       end
            4'd7:  begin res = {S[WIDTH-2:0], 1'b0}; res_c = S[WIDTH-1]; end
            4'd8:  res = R & S;
            4'd9:  res = R | S;
            4'd10: res = R ^ S;
            4'd11: res = ~S;
            4'd12: begin res = '0 - S; res_c = |S; end
            default: res_err = 1'b1;
        endcase
    end

    always_comb begin
        y_d   = y_q;
        n_d   = n_q;
        z_d   = z_q;
        c_d   = c_q;
        v_d   = v_q;
        err_d = err_q;
        vld_d = vld_q && !out_ready;

        if (accept && !is_mul) begin
            y_d   = res;
            n_d   = res[WIDTH-1];
            z_d   = (res == '0);
            c_d   = res_c;
            v_d   = res_v;
            err_d = res_err;
            vld_d = 1'b1;
        end

`ifdef ALU_PIPE_MUL_EN
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        prod     = acc_q + (mplier_q[0] ? mcand_q : '0);

        case (state_q)
            IDLE: begin
                if (accept && is_mul) begin
                    state_d  = MULT;
                    acc_d    = '0;
                    mcand_d  = {{WIDTH{1'b0}}, R};
                    mplier_d = S;
                    cnt_d    = '0;
                end
            end
            MULT: begin
                if (cnt_q != CW'(WIDTH - 1)) begin
                    acc_d    = prod;
                    mcand_d  = mcand_q << 1;
                    mplier_d = mplier_q >> 1;
                    cnt_d    = cnt_q + CW'(1);
                end else if (!vld_q || out_ready) begin
                    // final iteration folds straight into the result registers
                    y_d     = prod[WIDTH-1:0];
                    n_d     = prod[WIDTH-1];
                    z_d     = (prod[WIDTH-1:0] == '0);
                    c_d     = |prod[2*WIDTH-1:WIDTH];
                    v_d     = 1'b0;
                    err_d   = 1'b0;
                    vld_d   = 1'b1;
                    state_d = IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            default: state_d = IDLE;
        endcase
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            y_q      <= '0;
            n_q      <= 1'b0;
            z_q      <= 1'b0;
            c_q      <= 1'b0;
            v_q      <= 1'b0;
            err_q    <= 1'b0;
            vld_q    <= 1'b0;
            rdy_en_q <= 1'b0;
        end else begin
            y_q      <= y_d;
            n_q      <= n_d;
            z_q      <= z_d;
            c_q      <= c_d;
            v_q      <= v_d;
            err_q    <= err_d;
            vld_q    <= vld_d;
            rdy_en_q <= 1'b1;
        end
    end

`ifdef ALU_PIPE_MUL_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
        end
    end
`endif

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe (WIDTH=16); multiplier checks follow ALU_PIPE_MUL_EN.
module tb_alu_pipe;

    localparam int W = 16;
    localparam int unsigned MASK = 32'h0000_FFFF;

    typedef struct packed {
        logic [W-1:0] y;
        logic n, z, c, v, err;
    } res_t;

    typedef struct {
        logic [3:0]   op;
        logic [W-1:0] r;
        logic [W-1:0] s;
    } op_t;

    logic         clk = 1'b0;
    logic         reset = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] R = '0;
    logic [W-1:0] S = '0;
    logic [3:0]   Alu_Op = '0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] Y;
    logic         N, Z, C, V, err, busy;

    res_t act;
    res_t sb[$];
    int   n_checks = 0;
    int   n_fail = 0;

    assign act = {Y, N, Z, C, V, err};

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(W)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .R(R), .S(S), .Alu_Op(Alu_Op),
        .out_valid(out_valid), .out_ready(out_ready),
        .Y(Y), .N(N), .Z(Z), .C(C), .V(V), .err(err), .busy(busy)
    );

    function automatic int to_signed(input int unsigned x);
        return (x >= 32768) ? int'(x) - 65536 : int'(x);
    endfunction

    function automatic res_t model(input logic [3:0] op, input logic [W-1:0] r, input logic [W-1:0] s);
        res_t e;
        int unsigned ru, su, t;
        int st;
        longint unsigned p;
        e  = '0;
        ru = r;
        su = s;
        t  = 0;
        case (op)
            4'd0:  t = su;
            4'd1:  t = ru;
            4'd2:  begin t = su + 1; e.c = (su == MASK); end
            4'd3:  begin t = su - 1; e.c = (su == 0);    end
            4'd4: begin
                t = ru + su; e.c = (t > MASK);
                st = to_signed(ru) + to_signed(su); e.v = (st > 32767) || (st < -32768);
            end
            4'd5: begin
                t = ru - su; e.c = (ru < su);
                st = to_signed(ru) - to_signed(su); e.v = (st > 32767) || (st < -32768);
            end
            4'd6:  begin t = su / 2; e.c = (su % 2 == 1); end
            4'd7:  begin t = su * 2; e.c = (su >= 32768); end
            4'd8:  t = ru & su;
            4'd9:  t = ru | su;
            4'd10: t = ru ^ su;
            4'd11: t = ~su;
            4'd12: begin t = 65536 - su; e.c = (su != 0); end
`ifdef ALU_PIPE_MUL_EN
            4'd13: begin p = longint'(ru) * longint'(su); t = int'(p & 64'hFFFF); e.c = (p > 64'hFFFF); end
`endif
            default: begin t = 0; e.err = 1'b1; end
        endcase
        e.y = W'(t & MASK);
        e.n = e.y[W-1];
        e.z = (e.y == 0);
        return e;
    endfunction

    task automatic drive(input logic [3:0] op, input logic [W-1:0] r, input logic [W-1:0] s);
        in_valid = 1'b1;
        Alu_Op   = op;
        R        = r;
        S        = s;
    endtask

    task automatic test_reset;
        reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({out_valid, busy, act} !== '0) begin
            n_fail++; $display("FAIL reset_outputs: actual %h required 0", {out_valid, busy, act});
        end
        n_checks++;
        if (in_ready !== 1'b0) begin
            n_fail++; $display("FAIL reset_in_ready: actual %b required 0", in_ready);
        end
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1'b1) begin
            n_fail++; $display("FAIL in_ready_after_release: actual %b required 1", in_ready);
        end
    endtask

    task automatic test_back_to_back;
        op_t  ops[$];
        op_t  o;
        res_t e, k_exp;
        ops.push_back('{4'd4,  16'hBC45, 16'h86AB});
        ops.push_back('{4'd5,  16'hBD53, 16'h5555});
        ops.push_back('{4'd12, 16'h0000, 16'hDF52});
        ops.push_back('{4'd2,  16'h1234, 16'hFFFF});
        ops.push_back('{4'd3,  16'h1234, 16'h0000});
        ops.push_back('{4'd5,  16'h0001, 16'h0002});
        for (int i = 0; i < 40; i++) begin
            o.op = 4'($urandom_range(0, 15));
`ifdef ALU_PIPE_MUL_EN
            if (o.op == 4'd13) o.op = 4'd4;
`endif
            o.r = W'($urandom);
            o.s = W'($urandom);
            ops.push_back(o);
        end
        out_ready = 1'b1;
        for (int k = 0; k <= ops.size(); k++) begin
            @(posedge clk); #1;
            if (k < ops.size()) begin
                drive(ops[k].op, ops[k].r, ops[k].s);
                sb.push_back(model(ops[k].op, ops[k].r, ops[k].s));
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            if (k > 0) begin
                e = sb.pop_front();
                n_checks++;
                if (out_valid !== 1'b1) begin
                    n_fail++; $display("FAIL b2b_latency[%0d]: actual out_valid=%b required 1", k - 1, out_valid);
                end
                n_checks++;
                if (act !== e) begin
                    n_fail++; $display("FAIL b2b_result[%0d] op=%0d: actual {Y,N,Z,C,V,err}=%h required %h",
                                       k - 1, ops[k-1].op, act, e);
                end
                if (k <= 3) begin
                    if (k == 1) k_exp = '{y: 16'h42F0, n: 1'b0, z: 1'b0, c: 1'b1, v: 1'b1, err: 1'b0};
                    else if (k == 2) k_exp = '{y: 16'h67FE, n: 1'b0, z: 1'b0, c: 1'b0, v: 1'b1, err: 1'b0};
                    else k_exp = '{y: 16'h20AE, n: 1'b0, z: 1'b0, c: 1'b1, v: 1'b0, err: 1'b0};
                    n_checks++;
                    if (act !== k_exp) begin
                        n_fail++; $display("FAIL known_vector[%0d]: actual %h required %h", k - 1, act, k_exp);
                    end
                end
            end
            if (k < ops.size()) begin
                n_checks++;
                if (in_ready !== 1'b1) begin
                    n_fail++; $display("FAIL b2b_in_ready[%0d]: actual %b required 1", k, in_ready);
                end
            end
        end
    endtask

    task automatic test_hold;
        res_t e, k_exp;
        k_exp = '{y: 16'h9ABC, n: 1'b1, z: 1'b0, c: 1'b0, v: 1'b0, err: 1'b0};
        @(posedge clk); #1;
        out_ready = 1'b0;
        drive(4'd1, 16'h9ABC, 16'h0F0F);
        sb.push_back(model(4'd1, 16'h9ABC, 16'h0F0F));
        @(posedge clk); #1;
        in_valid = 1'b0;
        e = sb.pop_front();
        for (int i = 0; i < 5; i++) begin
            R = W'($urandom);
            S = W'($urandom);
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1 || act !== k_exp || act !== e || in_ready !== 1'b0) begin
                n_fail++; $display("FAIL hold[%0d]: actual vld=%b rdy=%b res=%h required vld=1 rdy=0 res=%h",
                                   i, out_valid, in_ready, act, k_exp);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL hold_release: actual out_valid=%b required 0", out_valid);
        end
    endtask

    task automatic test_illegal;
        logic [3:0] ops[$];
        res_t e, k_exp;
        k_exp = '{y: '0, n: 1'b0, z: 1'b1, c: 1'b0, v: 1'b0, err: 1'b1};
        ops.push_back(4'd14);
        ops.push_back(4'd15);
`ifndef ALU_PIPE_MUL_EN
        ops.push_back(4'd13);
`endif
        out_ready = 1'b1;
        foreach (ops[j]) begin
            @(posedge clk); #1;
            drive(ops[j], W'($urandom), W'($urandom));
            sb.push_back(model(ops[j], R, S));
            @(negedge clk);
            n_checks++;
            if (busy !== 1'b0) begin
                n_fail++; $display("FAIL illegal_busy op=%0d: actual %b required 0", ops[j], busy);
            end
            @(posedge clk); #1;
            in_valid = 1'b0;
            e = sb.pop_front();
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1 || act !== e || act !== k_exp || busy !== 1'b0) begin
                n_fail++; $display("FAIL illegal op=%0d: actual vld=%b busy=%b res=%h required vld=1 busy=0 res=%h",
                                   ops[j], out_valid, busy, act, k_exp);
            end
        end
    endtask

`ifdef ALU_PIPE_MUL_EN
    task automatic test_mul;
        res_t e, k_exp;
        int   busy_cycles;
        bit   seen;
        logic [W-1:0] ra, sa;
        k_exp = '{y: '0, n: 1'b0, z: 1'b1, c: 1'b1, v: 1'b0, err: 1'b0};
        out_ready = 1'b1;
        @(posedge clk); #1;
        drive(4'd13, 16'h0100, 16'h0100);
        sb.push_back(model(4'd13, 16'h0100, 16'h0100));
        @(posedge clk); #1;
        in_valid = 1'b0;
        busy_cycles = 0;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen = 1'b1;
            else if (busy === 1'b1 && in_ready === 1'b0) busy_cycles++;
        end
        e = sb.pop_front();
        n_checks++;
        if (!seen || busy_cycles != W) begin
            n_fail++; $display("FAIL mul_latency: actual busy_cycles=%0d seen=%0d required %0d seen=1", busy_cycles, seen, W);
        end
        n_checks++;
        if (act !== e || act !== k_exp || busy !== 1'b0) begin
            n_fail++; $display("FAIL mul_result: actual %h busy=%b required %h busy=0", act, busy, k_exp);
        end

        ra = W'($urandom);
        sa = W'($urandom);
        @(posedge clk); #1;
        out_ready = 1'b0;
        drive(4'd13, ra, sa);
        sb.push_back(model(4'd13, ra, sa));
        @(posedge clk); #1;
        in_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 100 && !seen; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) seen = 1'b1;
        end
        e = sb.pop_front();
        n_checks++;
        if (!seen) begin
            n_fail++; $display("FAIL mul2_timeout: actual out_valid=%b required 1", out_valid);
        end
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (out_valid !== 1'b1 || act !== e) begin
                n_fail++; $display("FAIL mul2_hold[%0d] %h*%h: actual vld=%b res=%h required vld=1 res=%h",
                                   i, ra, sa, out_valid, act, e);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b0) begin
            n_fail++; $display("FAIL mul2_release: actual out_valid=%b required 0", out_valid);
        end
    endtask
`endif

    task automatic test_reset_mul;
        res_t e, k_exp;
        int   stray;
        k_exp = '{y: '0, n: 1'b0, z: 1'b1, c: 1'b1, v: 1'b0, err: 1'b0};
        out_ready = 1'b1;
        @(posedge clk); #1;
        drive(4'd13, 16'h1234, 16'h5678);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        n_checks++;
        if ({out_valid, busy, in_ready, act} !== '0) begin
            n_fail++; $display("FAIL reset_abort: actual %h required 0", {out_valid, busy, in_ready, act});
        end
        repeat (2) @(negedge clk);
        reset = 1'b1;
        stray = 0;
        for (int i = 0; i < 2 * W + 4; i++) begin
            @(negedge clk);
            if (out_valid !== 1'b0 || busy !== 1'b0) stray++;
        end
        n_checks++;
        if (stray != 0) begin
            n_fail++; $display("FAIL reset_no_result: actual stray_cycles=%0d required 0", stray);
        end
        @(posedge clk); #1;
        drive(4'd2, 16'h0000, 16'hFFFF);
        sb.push_back(model(4'd2, 16'h0000, 16'hFFFF));
        @(posedge clk); #1;
        in_valid = 1'b0;
        e = sb.pop_front();
        @(negedge clk);
        n_checks++;
        if (out_valid !== 1'b1 || act !== e || act !== k_exp) begin
            n_fail++; $display("FAIL post_reset_inc: actual vld=%b res=%h required vld=1 res=%h", out_valid, act, k_exp);
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_hold();
        test_illegal();
`ifdef ALU_PIPE_MUL_EN
        test_mul();
`endif
        test_reset_mul();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
